uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Parses the byte stream from the UART receiver into calculator commands. Accepts ASCII expressions of the form `<A><op><B><terminator>` (e.g. "12+34\r"), converts both decimal operands to binary and presents operand A, operand B and an opcode to the arithmetic unit with a one-cycle valid strobe. Malformed input is discarded up to the next terminator and reported with an error strobe and code.

## Interface
Parameters:
- MAX_DIGITS, 4: maximum decimal digits per operand.
- OPW, 16: operand output width. Must hold 10^MAX_DIGITS − 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset. Asserted at 0.
- rx_data  in  8  received byte, valid while rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- operand_a  out  OPW  binary value of operand A. Held until the next cmd_valid.
- operand_b  out  OPW  binary value of operand B. Held until the next cmd_valid.
- opcode  out  2  0 add, 1 sub, 2 mul, 3 div. Held until the next cmd_valid.
- cmd_valid  out  1  one-cycle strobe when a well-formed command completes.
- cmd_error  out  1  one-cycle strobe when a malformed command is terminated.
- err_code  out  2  1 bad character, 2 too many digits, 3 missing operand/operator. Held until the next cmd_error.
- busy  out  1  high while a command is partially received (state ≠ S_A, or acc_cnt ≠ 0).

## Operation
- Character classes:
  - Digit: '0'–'9' (0x30–0x39).
  - Operator: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F.
  - Terminator: CR 0x0D or '=' 0x3D.
  - Space: 0x20, ignored in every state.
  - Clear: ESC 0x1B.
  - Anything else is bad.
- Bytes are processed only on cycles where rx_valid=1. All other cycles hold state.
- States:
  - S_A: collecting operand A.
    - Digit: acc ← acc*10 + digit, acc_cnt++.
    - Operator with acc_cnt≥1: latch A, latch opcode, clear acc, go to S_B.
    - Operator with acc_cnt=0: go to S_ERR with code 3.
    - Terminator: go to S_ERR with code 3 and fire immediately (see below).
  - S_B: collecting operand B.
    - Digit: accumulate as in S_A.
    - Terminator with acc_cnt≥1: latch B, pulse cmd_valid, return to S_A.
    - Terminator with acc_cnt=0: error code 3.
    - Operator: code 3.
  - S_ERR: discard bytes until a terminator, then pulse cmd_error and return to S_A.
- Error firing: a terminator received while entering an error condition pulses cmd_error directly; S_ERR is not visited.
- Error code priority: the first error detected in a command is the one reported. Later errors do not overwrite it.
- Digit overflow: a digit arriving when acc_cnt = MAX_DIGITS gives code 2.
- Bad character: any bad byte in S_A or S_B gives code 1.
- ESC in any state: clears acc, acc_cnt and the pending error; returns to S_A. No strobe is produced.
- Arithmetic: acc*10 is computed as (acc<<3)+(acc<<1) at OPW+4 bits, then truncated to OPW. No overflow is possible within MAX_DIGITS.
- Output holding: operand_a, operand_b and opcode change only in the cycle cmd_valid is raised.
- Reset: state=S_A; acc=0; acc_cnt=0. All outputs are 0: operand_a, operand_b, opcode, cmd_valid, cmd_error, err_code, busy.

## Timing
- cmd_valid and cmd_error are registered. Each rises on the clock edge after the terminator's rx_valid cycle and is high for exactly one cycle.
- operand_a, operand_b, opcode and err_code are stable from that same edge.
- cmd_valid and cmd_error are never high together.
- Back-to-back rx_valid on consecutive cycles must be handled. The UART spacing (~10400 cycles per byte) is not relied upon.
- Reset assertion mid-command discards the partial command immediately, asynchronously. Deassertion is synchronised externally.
- No backpressure. The consumer must accept cmd_valid in the cycle it is raised.

## Structure
- Shared package calc_pkg holds:
  - opcode encodings;
  - err_code encodings;
  - ASCII constants (CR, ESC, SPACE, '=', operators);
  - the state enum {S_A, S_B, S_ERR}.
- Sub-module ascii_classifier (combinational): takes rx_data; outputs is_digit, digit[3:0], is_op, op[1:0], is_term, is_space, is_esc, is_bad.
- The parser FSM and the accumulator live in the top module.

## Test plan
- "12+34\r" → one cmd_valid; operand_a=12, operand_b=34, opcode=0; cmd_error never high.
- "9999*0=" then "7/2\r" → two cmd_valid strobes, with (9999,0,2) and then (7,2,3); outputs hold between strobes.
- "12345+1\r" → cmd_error with err_code=2; no cmd_valid; the next "1-1\r" → cmd_valid with (1,1,1).
- "+5\r", then "5+\r", then "5+x3\r" → three cmd_error strobes with codes 3, 3, 1 respectively.
- "4 2 + 8\r" with bytes on consecutive cycles → cmd_valid with (42,8,0); "3+" then ESC then "1+1\r" → single cmd_valid with (1,1,0).
- Reset asserted after "56+" → all outputs 0 and busy=0 immediately; a following "2+2\r" → cmd_valid with (2,2,0).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the UART calculator command path: opcodes, error
// codes, the ASCII bytes the parser recognises, and the parser state enum.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD     = 2'd1;
    localparam logic [1:0] ERR_DIGITS  = 2'd2;
    localparam logic [1:0] ERR_MISSING = 2'd3;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_ERR = 2'd2
    } state_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte input and command output bundle between the UART receiver,
// the command parser and the arithmetic unit.
interface uart_cmd_parser_if #(
    parameter int OPW = 16
);
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic [OPW-1:0] operand_a;
    logic [OPW-1:0] operand_b;
    logic [1:0]     opcode;
    logic           cmd_valid;
    logic           cmd_error;
    logic [1:0]     err_code;
    logic           busy;

    // Byte source and command consumer side
    modport master (
        output rx_data, rx_valid,
        input  operand_a, operand_b, opcode, cmd_valid, cmd_error, err_code, busy
    );

    // Parser side
    modport slave (
        input  rx_data, rx_valid,
        output operand_a, operand_b, opcode, cmd_valid, cmd_error, err_code, busy
    );
endinterface

// File: rtl/ascii_classifier.sv
// Splits a received byte into the character classes the parser acts on.
// Exactly one class flag is high for any byte.
module ascii_classifier
    import calc_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_op,
    output logic [1:0] op,
    output logic       is_term,
    output logic       is_space,
    output logic       is_esc,
    output logic       is_bad
);

    // Decode the byte into its class and, for digits/operators, its value
    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        is_op    = 1'b0;
        op       = OP_ADD;
        is_term  = 1'b0;
        is_space = 1'b0;
        is_esc   = 1'b0;
        is_bad   = 1'b0;
        if (rx_data >= CH_0 && rx_data <= CH_9) begin
            is_digit = 1'b1;
            digit    = rx_data[3:0];
        end else begin
            case (rx_data)
                CH_PLUS:  begin is_op = 1'b1; op = OP_ADD; end
                CH_MINUS: begin is_op = 1'b1; op = OP_SUB; end
                CH_STAR:  begin is_op = 1'b1; op = OP_MUL; end
                CH_SLASH: begin is_op = 1'b1; op = OP_DIV; end
                CH_CR,
                CH_EQ:    is_term  = 1'b1;
                CH_SPACE: is_space = 1'b1;
                CH_ESC:   is_esc   = 1'b1;
                default:  is_bad   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns the UART byte stream "<A><op><B><terminator>" into a binary
// operand/opcode command with a one-cycle strobe; malformed commands are
// swallowed up to the next terminator and reported with an error code.
module uart_cmd_parser
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int OPW        = 16
) (
    input logic              clk,
    input logic              reset,
    uart_cmd_parser_if.slave bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic           is_digit, is_op, is_term, is_space, is_esc, is_bad;
    logic [3:0]     digit;
    logic [1:0]     op;

    state_t         state, state_n;
    logic [OPW-1:0] acc, acc_n, acc_next;
    logic [CW-1:0]  acc_cnt, cnt_n;
    logic [1:0]     err_pend, err_n;
    logic [OPW-1:0] a_lat, a_n;
    logic [1:0]     op_lat, op_n;
    logic           fire_valid, fire_error;
    logic [1:0]     fire_code;
    logic [OPW+3:0] acc_ext, acc_x10;

    ascii_classifier u_class (
        .rx_data  (bus.rx_data),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .op       (op),
        .is_term  (is_term),
        .is_space (is_space),
        .is_esc   (is_esc),
        .is_bad   (is_bad)
    );

    // Decimal accumulate: acc*10 as two shifts plus the new digit, kept wide then truncated
    always_comb begin
        acc_ext  = {4'b0000, acc};
        acc_x10  = (acc_ext << 3) + (acc_ext << 1) + {{OPW{1'b0}}, digit};
        acc_next = acc_x10[OPW-1:0];
    end

    // Parser next state: one byte per rx_valid cycle, errors latched first-wins
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = acc_cnt;
        err_n      = err_pend;
        a_n        = a_lat;
        op_n       = op_lat;
        fire_valid = 1'b0;
        fire_error = 1'b0;
        fire_code  = err_pend;
        if (bus.rx_valid) begin
            if (is_esc) begin
                state_n = S_A;
                acc_n   = '0;
                cnt_n   = '0;
                err_n   = ERR_NONE;
            end else if (!is_space) begin
                case (state)
                    S_A, S_B: begin
                        if (is_digit) begin
                            if (acc_cnt == CW'(MAX_DIGITS)) begin
                                state_n = S_ERR;
                                err_n   = ERR_DIGITS;
                            end else begin
                                acc_n = acc_next;
                                cnt_n = acc_cnt + CW'(1);
                            end
                        end else if (is_op) begin
                            if (state == S_A && acc_cnt != '0) begin
                                a_n     = acc;
                                op_n    = op;
                                acc_n   = '0;
                                cnt_n   = '0;
                                state_n = S_B;
                            end else begin
                                state_n = S_ERR;
                                err_n   = ERR_MISSING;
                            end
                        end else if (is_term) begin
                            if (state == S_B && acc_cnt != '0) begin
                                fire_valid = 1'b1;
                            end else begin
                                fire_error = 1'b1;
                                fire_code  = ERR_MISSING;
                            end
                            state_n = S_A;
                            acc_n   = '0;
                            cnt_n   = '0;
                            err_n   = ERR_NONE;
                        end else if (is_bad) begin
                            state_n = S_ERR;
                            err_n   = ERR_BAD;
                        end
                    end
                    S_ERR: begin
                        if (is_term) begin
                            fire_error = 1'b1;
                            fire_code  = err_pend;
                            state_n    = S_A;
                            acc_n      = '0;
                            cnt_n      = '0;
                            err_n      = ERR_NONE;
                        end
                    end
                    default: begin
                        state_n = S_A;
                        acc_n   = '0;
                        cnt_n   = '0;
                        err_n   = ERR_NONE;
                    end
                endcase
            end
        end
    end

    // State, accumulator and registered command outputs; reset drops any partial command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_A;
            acc           <= '0;
            acc_cnt       <= '0;
            err_pend      <= ERR_NONE;
            a_lat         <= '0;
            op_lat        <= OP_ADD;
            bus.operand_a <= '0;
            bus.operand_b <= '0;
            bus.opcode    <= OP_ADD;
            bus.cmd_valid <= 1'b0;
            bus.cmd_error <= 1'b0;
            bus.err_code  <= ERR_NONE;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            acc_cnt       <= cnt_n;
            err_pend      <= err_n;
            a_lat         <= a_n;
            op_lat        <= op_n;
            bus.cmd_valid <= fire_valid;
            bus.cmd_error <= fire_error;
            if (fire_valid) begin
                bus.operand_a <= a_lat;
                bus.operand_b <= acc;
                bus.opcode    <= op_lat;
            end
            if (fire_error) begin
                bus.err_code <= fire_code;
            end
        end
    end

    assign bus.busy = (state != S_A) || (acc_cnt != '0);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a table of command strings with
// hand-computed results, plus hand-written reset sequences.
module tb_uart_cmd_parser;

    logic clk;
    logic reset;

    uart_cmd_parser_if #(.OPW(16)) bus ();

    uart_cmd_parser #(.MAX_DIGITS(4), .OPW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       cmd;
        int          n_valid;
        int          n_error;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic addVec(input string cmd, input int nv, input int ne,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [1:0] code);
        vec_t v;
        v.cmd = cmd; v.n_valid = nv; v.n_error = ne;
        v.a = a; v.b = b; v.op = op; v.code = code;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive a string on consecutive cycles, counting strobes over the whole burst
    task automatic applyStimulus(input string s, output int n_valid, output int n_error);
        n_valid = 0;
        n_error = 0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            n_valid += int'(bus.cmd_valid);
            n_error += int'(bus.cmd_error);
            bus.rx_data  = s[i];
            bus.rx_valid = 1'b1;
        end
        @(negedge clk);
        n_valid += int'(bus.cmd_valid);
        n_error += int'(bus.cmd_error);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        n_valid += int'(bus.cmd_valid);
        n_error += int'(bus.cmd_error);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_operand_a"}, 32'(bus.operand_a), 32'd0);
        checkOutput({tag, "_operand_b"}, 32'(bus.operand_b), 32'd0);
        checkOutput({tag, "_opcode"},    32'(bus.opcode),    32'd0);
        checkOutput({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        checkOutput({tag, "_cmd_error"}, 32'(bus.cmd_error), 32'd0);
        checkOutput({tag, "_err_code"},  32'(bus.err_code),  32'd0);
        checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        int nv, ne;

        // cmd, #valid, #error, operand_a, operand_b, opcode, err_code (after the string)
        addVec("12+34\015",           1, 0,   12, 34, 2'd0, 2'd0);
        addVec("9999*0=",             1, 0, 9999,  0, 2'd2, 2'd0);
        addVec("7/2\015",             1, 0,    7,  2, 2'd3, 2'd0);
        addVec("12345+1\015",         0, 1,    7,  2, 2'd3, 2'd2);
        addVec("1-1\015",             1, 0,    1,  1, 2'd1, 2'd2);
        addVec("+5\015",              0, 1,    1,  1, 2'd1, 2'd3);
        addVec("5+\015",              0, 1,    1,  1, 2'd1, 2'd3);
        addVec("5+x3\015",            0, 1,    1,  1, 2'd1, 2'd1);
        addVec("4 2 + 8\015",         1, 0,   42,  8, 2'd0, 2'd1);
        addVec("3+\0331+1\015",       1, 0,    1,  1, 2'd0, 2'd1);
        addVec("12=",                 0, 1,    1,  1, 2'd0, 2'd3);
        addVec("\033",                0, 0,    1,  1, 2'd0, 2'd3);
        addVec("12a+1\015",           0, 1,    1,  1, 2'd0, 2'd1);
        addVec("+x\015",              0, 1,    1,  1, 2'd0, 2'd3);
        addVec("9x+\015",             0, 1,    1,  1, 2'd0, 2'd1);
        addVec("1+2+3\015",           0, 1,    1,  1, 2'd0, 2'd3);
        addVec("250*4000=",           1, 0,  250, 4000, 2'd2, 2'd3);

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            applyStimulus(vecs[k].cmd, nv, ne);
            checkOutput({tag, "_n_valid"},   32'(nv),             32'(vecs[k].n_valid));
            checkOutput({tag, "_n_error"},   32'(ne),             32'(vecs[k].n_error));
            checkOutput({tag, "_operand_a"}, 32'(bus.operand_a),  32'(vecs[k].a));
            checkOutput({tag, "_operand_b"}, 32'(bus.operand_b),  32'(vecs[k].b));
            checkOutput({tag, "_opcode"},    32'(bus.opcode),     32'(vecs[k].op));
            checkOutput({tag, "_err_code"},  32'(bus.err_code),   32'(vecs[k].code));
            checkOutput({tag, "_busy"},      32'(bus.busy),       32'd0);
        end

        // Exact strobe timing: high on the edge after the terminator, gone one cycle later
        @(negedge clk);
        bus.rx_data = "8"; bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_data = "+";
        @(negedge clk);
        bus.rx_data = "6";
        @(negedge clk);
        bus.rx_data = "=";
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("timing_cmd_valid_high", 32'(bus.cmd_valid), 32'd1);
        checkOutput("timing_cmd_error_low",  32'(bus.cmd_error), 32'd0);
        checkOutput("timing_operand_a",      32'(bus.operand_a), 32'd8);
        checkOutput("timing_operand_b",      32'(bus.operand_b), 32'd6);
        @(negedge clk);
        checkOutput("timing_cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);

        // Partial command, then asynchronous reset between clock edges
        applyStimulus("56+", nv, ne);
        checkOutput("partial_busy",    32'(bus.busy), 32'd1);
        checkOutput("partial_strobes", 32'(nv + ne),  32'd0);
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus("2+2\015", nv, ne);
        checkOutput("post_reset_n_valid",   32'(nv),             32'd1);
        checkOutput("post_reset_n_error",   32'(ne),             32'd0);
        checkOutput("post_reset_operand_a", 32'(bus.operand_a),  32'd2);
        checkOutput("post_reset_operand_b", 32'(bus.operand_b),  32'd2);
        checkOutput("post_reset_opcode",    32'(bus.opcode),     32'd0);
        checkOutput("post_reset_err_code",  32'(bus.err_code),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
